// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS MEM-stage data memory.
//   - load/store opcode constants (instruction bits 31:26)
//   - access-size enum and FSM state encoding
//   - small opcode decode helpers
package mips_pkg;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    function automatic logic is_load(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    // Only meaningful for load/store opcodes; other ops fall through to WORD
    // and are gated off by the caller.
    function automatic size_e op_size(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: return SZ_HALF;
            default:              return SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/dm_lane_unit.sv
// Combinational byte-lane logic for the data memory.
// Ports:
//   op        in  6   M-stage opcode
//   lane      in  2   byte lane of the access (offset bits 1:0)
//   wdata     in  32  store data (sub-word data taken from low bits)
//   rword     in  32  word currently stored at the access index
//   be        out 4   byte enables of the store
//   merged    out 32  rword with the enabled lanes replaced by store data
//   load_val  out 32  extended load result
//   misalign  out 1   access violates the size alignment rule
module dm_lane_unit
    import mips_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] merged,
    output logic [31:0] load_val,
    output logic        misalign
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic        sgn;

    assign rd_byte = rword[{lane, 3'b000} +: 8];
    assign rd_half = lane[1] ? rword[31:16] : rword[15:0];
    assign sgn     = (op == OP_LB) || (op == OP_LH);

    always_comb begin
        // NOTE: every output gets a default first so no path through the
        // case leaves a variable unassigned (which would infer a latch).
        be       = 4'b0000;
        merged   = rword;
        load_val = 32'h0;
        misalign = 1'b0;
        case (op_size(op))
            SZ_BYTE: begin
                be                       = 4'b0001 << lane;
                merged[{lane, 3'b000} +: 8] = wdata[7:0];
                load_val                 = {{24{sgn & rd_byte[7]}}, rd_byte};
            end
            SZ_HALF: begin
                misalign = lane[0];
                be       = lane[1] ? 4'b1100 : 4'b0011;
                if (lane[1]) merged[31:16] = wdata[15:0];
                else         merged[15:0]  = wdata[15:0];
                load_val = {{16{sgn & rd_half[15]}}, rd_half};
            end
            default: begin
                misalign = (lane != 2'b00);
                be       = 4'b1111;
                merged   = wdata;
                load_val = rword;
            end
        endcase
    end

endmodule

// File: rtl/dm_mem_stage_ext.sv
// MEM-stage data memory: word array with sub-word stores, extending loads,
// address-error detection and a post-reset clear engine that stalls the
// pipeline (dm_busy) until every word has been zeroed.
// Ports:
//   clk       in  1   rising-edge clock
//   reset     in  1   asynchronous active-high reset
//   instr_m   in  32  M-stage instruction (op = bits 31:26)
//   alu_out   in  32  effective byte address
//   rt_data   in  32  store data
//   dm_out    out 32  extended load result (combinational)
//   dm_busy   out 1   clear engine running / reset active
//   exc_adel  out 1   load address error
//   exc_ades  out 1   store address error
module dm_mem_stage_ext
    import mips_pkg::*;
#(
    parameter int          DEPTH_LOG2     = 10,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_m,
    input  logic [31:0] alu_out,
    input  logic [31:0] rt_data,
    output logic [31:0] dm_out,
    output logic        dm_busy,
    output logic        exc_adel,
    output logic        exc_ades
);

    localparam int WORDS = 2 ** DEPTH_LOG2;

    logic [31:0]           mem [WORDS];
    state_e                state;
    logic [DEPTH_LOG2-1:0] clr_ptr;

    logic [5:0]            op;
    logic [31:0]           off;
    logic                  in_range;
    logic [DEPTH_LOG2-1:0] idx;
    logic [1:0]            lane;
    logic [31:0]           rword;
    logic [31:0]           merged;
    logic [31:0]           load_val;
    logic [3:0]            be;
    logic                  misalign;
    logic                  run;
    logic                  ld;
    logic                  st;
    logic                  bad;
    logic                  we;
    logic                  unused_bits;

    assign op          = instr_m[31:26];
    assign unused_bits = ^{instr_m[25:0], be};

    // Offset from the array base; anything above the array's byte span is
    // out of range, so the upper offset bits must all be zero.
    assign off      = alu_out - BASE_ADDR;
    assign in_range = (off >> (DEPTH_LOG2 + 2)) == 32'h0;
    assign idx      = off[DEPTH_LOG2+1:2];
    assign lane     = off[1:0];
    assign rword    = mem[idx];

    dm_lane_unit u_lane (
        .op       (op),
        .lane     (lane),
        .wdata    (rt_data),
        .rword    (rword),
        .be       (be),
        .merged   (merged),
        .load_val (load_val),
        .misalign (misalign)
    );

    // Reset is folded in so outputs go quiet the instant reset asserts.
    assign run = (state == ST_RUN) && !reset;
    assign ld  = is_load(op);
    assign st  = is_store(op);
    assign bad = misalign || !in_range;
    assign we  = run && st && !bad;

    assign dm_busy  = !run;
    assign exc_adel = run && ld && bad;
    assign exc_ades = run && st && bad;
    assign dm_out   = (run && ld && !bad) ? load_val : 32'h0;

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            state   <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            clr_ptr <= '0;
        end else if (state == ST_CLEAR) begin
            clr_ptr <= clr_ptr + 1'b1;
            if (&clr_ptr) state <= ST_RUN;
        end
    end

    // NOTE: the array has no reset branch -- a RAM cannot be reset in one
    // cycle; the clear engine zeroes it word by word instead.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == ST_CLEAR) mem[clr_ptr] <= 32'h0;
            else if (we)           mem[idx]     <= merged;
        end
    end

endmodule

// File: tb/tb_dm_mem_stage_ext.sv
module tb_dm_mem_stage_ext;
    import mips_pkg::*;

    localparam int DL2   = 4;
    localparam int WORDS = 16;
    localparam int NV    = 24;
    localparam logic [5:0] OP_NOP = 6'b000000;
    localparam logic [5:0] OP_LWL = 6'b100010;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr_m = 32'h0;
    logic [31:0] alu_out = 32'h0;
    logic [31:0] rt_data = 32'h0;
    logic [31:0] dm_out;
    logic        dm_busy;
    logic        exc_adel;
    logic        exc_ades;

    dm_mem_stage_ext #(
        .DEPTH_LOG2     (DL2),
        .BASE_ADDR      (32'h0000_0000),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .instr_m  (instr_m),
        .alu_out  (alu_out),
        .rt_data  (rt_data),
        .dm_out   (dm_out),
        .dm_busy  (dm_busy),
        .exc_adel (exc_adel),
        .exc_ades (exc_ades)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_out;
        logic        exp_adel;
        logic        exp_ades;
    } vec_t;

    typedef struct {
        int          id;
        logic [31:0] out;
        logic        adel;
        logic        ades;
    } exp_t;

    vec_t vec [NV];
    exp_t sb_q [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        instr_m = {op, 26'h0};
        alu_out = addr;
        rt_data = data;
    endtask

    // Counts cycles until dm_busy drops, bounded so a stuck engine cannot hang.
    task automatic wait_clear(output int cycles);
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
        end while (dm_busy && cycles < 200);
        instr_m = 32'h0;
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < WORDS; i++) begin
            drive(OP_LW, 32'(i * 4), 32'h0);
            #1;
            check($sformatf("%s word%0d", tag, i), dm_out, 32'h0);
        end
    endtask

    initial begin
        int   cyc;
        exp_t e;

        vec[0]  = '{OP_SW,  32'h10, 32'h8899AABB, 32'h00000000, 1'b0, 1'b0};
        vec[1]  = '{OP_LB,  32'h13, 32'h0,        32'hFFFFFF88, 1'b0, 1'b0};
        vec[2]  = '{OP_LBU, 32'h13, 32'h0,        32'h00000088, 1'b0, 1'b0};
        vec[3]  = '{OP_LH,  32'h12, 32'h0,        32'hFFFF8899, 1'b0, 1'b0};
        vec[4]  = '{OP_LHU, 32'h12, 32'h0,        32'h00008899, 1'b0, 1'b0};
        vec[5]  = '{OP_LB,  32'h10, 32'h0,        32'hFFFFFFBB, 1'b0, 1'b0};
        vec[6]  = '{OP_LBU, 32'h11, 32'h0,        32'h000000AA, 1'b0, 1'b0};
        vec[7]  = '{OP_LH,  32'h10, 32'h0,        32'hFFFFAABB, 1'b0, 1'b0};
        vec[8]  = '{OP_SB,  32'h11, 32'hFFFFFF55, 32'h00000000, 1'b0, 1'b0};
        vec[9]  = '{OP_LW,  32'h10, 32'h0,        32'h889955BB, 1'b0, 1'b0};
        vec[10] = '{OP_SH,  32'h10, 32'hFFFF1234, 32'h00000000, 1'b0, 1'b0};
        vec[11] = '{OP_LW,  32'h10, 32'h0,        32'h88991234, 1'b0, 1'b0};
        vec[12] = '{OP_SB,  32'h13, 32'h0000007F, 32'h00000000, 1'b0, 1'b0};
        vec[13] = '{OP_LB,  32'h13, 32'h0,        32'h0000007F, 1'b0, 1'b0};
        vec[14] = '{OP_LW,  32'h06, 32'h0,        32'h00000000, 1'b1, 1'b0};
        vec[15] = '{OP_SH,  32'h07, 32'h0000FFFF, 32'h00000000, 1'b0, 1'b1};
        vec[16] = '{OP_LW,  32'h04, 32'h0,        32'h00000000, 1'b0, 1'b0};
        vec[17] = '{OP_SW,  32'h40, 32'hCAFEF00D, 32'h00000000, 1'b0, 1'b1};
        vec[18] = '{OP_LW,  32'h00, 32'h0,        32'h00000000, 1'b0, 1'b0};
        vec[19] = '{OP_LH,  32'h11, 32'h0,        32'h00000000, 1'b1, 1'b0};
        vec[20] = '{OP_SW,  32'h3C, 32'hDEADBEEF, 32'h00000000, 1'b0, 1'b0};
        vec[21] = '{OP_LW,  32'h3C, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0};
        vec[22] = '{OP_NOP, 32'h10, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0};
        vec[23] = '{OP_LWL, 32'h10, 32'h0,        32'h00000000, 1'b0, 1'b0};

        // Reset held 3 cycles with a misaligned load presented.
        instr_m = {OP_LW, 26'h0};
        alu_out = 32'h06;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset dm_busy", {31'b0, dm_busy}, 32'h1);
        check("reset dm_out", dm_out, 32'h0);
        check("reset exc_adel", {31'b0, exc_adel}, 32'h0);

        reset = 1'b0;
        #1;
        check("clear exc_adel", {31'b0, exc_adel}, 32'h0);
        wait_clear(cyc);
        check("clear busy cycles", 32'(cyc), 32'd16);
        check_all_zero("post-clear");

        // Table-driven run: expected results queued as stimulus is driven.
        for (int i = 0; i < NV; i++) begin
            drive(vec[i].op, vec[i].addr, vec[i].data);
            sb_q.push_back('{i, vec[i].exp_out, vec[i].exp_adel, vec[i].exp_ades});
            #1;
            e = sb_q.pop_front();
            check($sformatf("vec%0d dm_out", e.id), dm_out, e.out);
            check($sformatf("vec%0d exc_adel", e.id), {31'b0, exc_adel}, {31'b0, e.adel});
            check($sformatf("vec%0d exc_ades", e.id), {31'b0, exc_ades}, {31'b0, e.ades});
            check($sformatf("vec%0d dm_busy", e.id), {31'b0, dm_busy}, 32'h0);
        end
        drive(OP_LW, 32'h10, 32'h0);
        #1;
        check("nop left word intact", dm_out, 32'h7F991234);

        // Fill every word with garbage, then clear again with a mid-clear reset.
        for (int i = 0; i < WORDS; i++) drive(OP_SW, 32'(i * 4), 32'hA5A50000 | 32'(i));
        drive(OP_LW, 32'h14, 32'h0);
        #1;
        check("garbage word5", dm_out, 32'hA5A50005);

        @(negedge clk);
        reset = 1'b1;
        #1;
        check("async reset dm_busy", {31'b0, dm_busy}, 32'h1);
        check("async reset dm_out", dm_out, 32'h0);
        @(negedge clk);
        reset   = 1'b0;
        instr_m = {OP_SW, 26'h0};
        alu_out = 32'h20;
        rt_data = 32'h12345678;
        repeat (5) @(posedge clk);
        #1;
        check("mid-clear dm_busy", {31'b0, dm_busy}, 32'h1);
        check("mid-clear exc_ades", {31'b0, exc_ades}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        wait_clear(cyc);
        check("restart busy cycles", 32'(cyc), 32'd16);
        check_all_zero("restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard time limit so the bench always ends on its own.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
